// File: rtl/race_flow_if.sv
// Handshake bundle between the game sequencer and the rest of the racer.
// Carries button events, player positions and the sequencer outputs.
interface race_flow_if #(
    parameter int MAX_POS     = 109,
    parameter int COUNT_STEPS = 3
);
    localparam int PW = $clog2(MAX_POS);
    localparam int CW = $clog2(COUNT_STEPS + 1);

    logic          start_pulse;
    logic          abort_pulse;
    logic [PW-1:0] green_cur_pos;
    logic [PW-1:0] red_cur_pos;
    logic [PW-1:0] blue_cur_pos;
    logic [PW-1:0] yellow_cur_pos;

    logic          is_in_menu;
    logic          race_active;
    logic [CW-1:0] countdown;
    logic          clear_pos;
    logic [3:0]    winner;
    logic          tie;
    logic [1:0]    state;

    modport master (
        output start_pulse, abort_pulse,
        output green_cur_pos, red_cur_pos,
        output blue_cur_pos, yellow_cur_pos,
        input  is_in_menu, race_active, countdown,
        input  clear_pos, winner, tie, state
    );

    modport slave (
        input  start_pulse, abort_pulse,
        input  green_cur_pos, red_cur_pos,
        input  blue_cur_pos, yellow_cur_pos,
        output is_in_menu, race_active, countdown,
        output clear_pos, winner, tie, state
    );
endinterface

// File: rtl/race_flow_controller.sv
// LED racer game sequencer: MENU -> COUNTDOWN -> RACE -> FINISHED.
// Gates player movement, latches winners, pulses position clear.
module race_flow_controller #(
    parameter int MAX_POS        = 109,
    parameter int COUNT_STEPS    = 3,
    parameter int COUNT_TICKS    = 50000000,
    parameter int WIN_HOLD_TICKS = 250000000
) (
    input logic       clk,
    input logic       rst_n,
    race_flow_if.slave bus
);
    localparam int PW = $clog2(MAX_POS);
    localparam int CW = $clog2(COUNT_STEPS + 1);
    localparam int TW = $clog2(COUNT_TICKS);
    localparam int HW = $clog2(WIN_HOLD_TICKS);

    localparam logic [PW-1:0] FIN_POS  = PW'(MAX_POS - 1);
    localparam logic [TW-1:0] TICK_END = TW'(COUNT_TICKS - 1);
    localparam logic [HW-1:0] HOLD_END = HW'(WIN_HOLD_TICKS - 1);
    localparam logic [CW-1:0] CD_INIT  = CW'(COUNT_STEPS);
    localparam logic [CW-1:0] CD_ONE   = CW'(1);

    typedef enum logic [1:0] {
        MENU      = 2'd0,
        COUNTDOWN = 2'd1,
        RACE      = 2'd2,
        FINISHED  = 2'd3
    } state_e;

    state_e        state_q;
    logic [TW-1:0] tick_q;
    logic [HW-1:0] hold_q;
    logic [CW-1:0] countdown_q;
    logic          clear_q;
    logic [3:0]    winner_q;
    logic          tie_q;

    logic [3:0]    match_d;
    logic          multi_d;

    // Players sitting exactly on the last LED this cycle; no priority.
    always_comb begin
        match_d    = 4'b0000;
        match_d[0] = (bus.green_cur_pos  == FIN_POS);
        match_d[1] = (bus.red_cur_pos    == FIN_POS);
        match_d[2] = (bus.blue_cur_pos   == FIN_POS);
        match_d[3] = (bus.yellow_cur_pos == FIN_POS);
        multi_d    = |(match_d & (match_d - 4'd1));
    end

    // Game state machine; abort out of any non-menu state wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MENU;
            tick_q      <= '0;
            hold_q      <= '0;
            countdown_q <= '0;
            clear_q     <= 1'b0;
            winner_q    <= 4'b0000;
            tie_q       <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            if (bus.abort_pulse && state_q != MENU) begin
                state_q     <= MENU;
                tick_q      <= '0;
                hold_q      <= '0;
                countdown_q <= '0;
                winner_q    <= 4'b0000;
                tie_q       <= 1'b0;
            end else begin
                unique case (state_q)
                    MENU: begin
                        if (bus.start_pulse) begin
                            state_q     <= COUNTDOWN;
                            countdown_q <= CD_INIT;
                            tick_q      <= '0;
                            winner_q    <= 4'b0000;
                            tie_q       <= 1'b0;
                            clear_q     <= 1'b1;
                        end
                    end
                    COUNTDOWN: begin
                        if (tick_q == TICK_END) begin
                            tick_q <= '0;
                            if (countdown_q > CD_ONE) begin
                                countdown_q <= countdown_q - CD_ONE;
                            end else begin
                                countdown_q <= '0;
                                state_q     <= RACE;
                            end
                        end else begin
                            tick_q <= tick_q + TW'(1);
                        end
                    end
                    RACE: begin
                        if (|match_d) begin
                            state_q  <= FINISHED;
                            winner_q <= match_d;
                            tie_q    <= multi_d;
                            hold_q   <= '0;
                        end
                    end
                    FINISHED: begin
                        if (bus.start_pulse || hold_q == HOLD_END) begin
                            state_q  <= MENU;
                            hold_q   <= '0;
                            winner_q <= 4'b0000;
                            tie_q    <= 1'b0;
                        end else begin
                            hold_q <= hold_q + HW'(1);
                        end
                    end
                    default: state_q <= MENU;
                endcase
            end
        end
    end

    assign bus.is_in_menu  = (state_q == MENU);
    assign bus.race_active = (state_q == RACE);
    assign bus.countdown   = countdown_q;
    assign bus.clear_pos   = clear_q;
    assign bus.winner      = winner_q;
    assign bus.tie         = tie_q;
    assign bus.state       = state_q;
endmodule

// File: tb/tb_race_flow_controller.sv
// Directed bench for the racer game sequencer.
// Small timing overrides keep every phase a few cycles long.
module tb_race_flow_controller;
    localparam int MAX_POS        = 109;
    localparam int COUNT_STEPS    = 3;
    localparam int COUNT_TICKS    = 4;
    localparam int WIN_HOLD_TICKS = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    race_flow_if #(
        .MAX_POS(MAX_POS),
        .COUNT_STEPS(COUNT_STEPS)
    ) bus ();

    race_flow_controller #(
        .MAX_POS(MAX_POS),
        .COUNT_STEPS(COUNT_STEPS),
        .COUNT_TICKS(COUNT_TICKS),
        .WIN_HOLD_TICKS(WIN_HOLD_TICKS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_to_race();
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
        repeat (COUNT_STEPS * COUNT_TICKS) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.start_pulse    = 1'b0;
        bus.abort_pulse    = 1'b0;
        bus.green_cur_pos  = '0;
        bus.red_cur_pos    = '0;
        bus.blue_cur_pos   = '0;
        bus.yellow_cur_pos = '0;

        // Reset state
        repeat (3) tick();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_menu", 32'(bus.is_in_menu), 32'd1);
        check("rst_active", 32'(bus.race_active), 32'd0);
        check("rst_cd", 32'(bus.countdown), 32'd0);
        check("rst_clear", 32'(bus.clear_pos), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        check("rst_tie", 32'(bus.tie), 32'd0);
        rst_n = 1'b1;

        // Start at cycle 5, walk the countdown
        repeat (4) tick();
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
        check("cd_clear_first", 32'(bus.clear_pos), 32'd1);
        for (int i = 0; i < 12; i++) begin
            if (i == 5) bus.green_cur_pos = 7'd108;
            if (i == 6) bus.start_pulse = 1'b1;
            if (i == 7) bus.start_pulse = 1'b0;
            if (i == 10) bus.green_cur_pos = '0;
            check("cd_state", 32'(bus.state), 32'd1);
            check("cd_value", 32'(bus.countdown), 32'(3 - i / 4));
            check("cd_active", 32'(bus.race_active), 32'd0);
            if (i == 1) check("cd_clear_once", 32'(bus.clear_pos), 32'd0);
            tick();
        end
        check("race_state", 32'(bus.state), 32'd2);
        check("race_active", 32'(bus.race_active), 32'd1);
        check("race_cd", 32'(bus.countdown), 32'd0);
        check("race_menu", 32'(bus.is_in_menu), 32'd0);

        // Out-of-range position never finishes
        bus.blue_cur_pos = 7'd110;
        tick();
        tick();
        check("oor_state", 32'(bus.state), 32'd2);
        bus.blue_cur_pos = '0;
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
        check("race_ign_start", 32'(bus.state), 32'd2);

        // Single winner: red
        bus.red_cur_pos = 7'd108;
        tick();
        bus.red_cur_pos = '0;
        check("win_state", 32'(bus.state), 32'd3);
        check("win_winner", 32'(bus.winner), 32'b0010);
        check("win_tie", 32'(bus.tie), 32'd0);
        check("win_active", 32'(bus.race_active), 32'd0);
        repeat (7) tick();
        check("hold_last", 32'(bus.state), 32'd3);
        check("hold_winner", 32'(bus.winner), 32'b0010);
        tick();
        check("auto_menu", 32'(bus.state), 32'd0);
        check("auto_is_menu", 32'(bus.is_in_menu), 32'd1);
        check("auto_winner", 32'(bus.winner), 32'd0);

        // Tie: green and yellow together
        run_to_race();
        check("race2_state", 32'(bus.state), 32'd2);
        bus.green_cur_pos  = 7'd108;
        bus.yellow_cur_pos = 7'd108;
        tick();
        bus.green_cur_pos  = '0;
        bus.yellow_cur_pos = '0;
        check("tie_state", 32'(bus.state), 32'd3);
        check("tie_winner", 32'(bus.winner), 32'b1001);
        check("tie_flag", 32'(bus.tie), 32'd1);
        bus.blue_cur_pos = 7'd108;
        tick();
        bus.blue_cur_pos = '0;
        check("tie_hold_win", 32'(bus.winner), 32'b1001);
        check("tie_hold_st", 32'(bus.state), 32'd3);

        // Early exit at hold count 2
        tick();
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
        check("early_state", 32'(bus.state), 32'd0);
        check("early_winner", 32'(bus.winner), 32'd0);
        check("early_tie", 32'(bus.tie), 32'd0);

        // Abort with start mid-countdown
        bus.start_pulse = 1'b1;
        tick();
        bus.start_pulse = 1'b0;
        tick();
        tick();
        check("ab_pre_state", 32'(bus.state), 32'd1);
        bus.abort_pulse = 1'b1;
        bus.start_pulse = 1'b1;
        tick();
        bus.abort_pulse = 1'b0;
        bus.start_pulse = 1'b0;
        check("ab_state", 32'(bus.state), 32'd0);
        check("ab_cd", 32'(bus.countdown), 32'd0);
        check("ab_menu", 32'(bus.is_in_menu), 32'd1);

        // Async reset mid-race, between edges
        run_to_race();
        tick();
        check("rr_pre_state", 32'(bus.state), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_state", 32'(bus.state), 32'd0);
        check("ar_active", 32'(bus.race_active), 32'd0);
        check("ar_menu", 32'(bus.is_in_menu), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/race_flow_controller.md
Name: race_flow_controller

Overview:
Top-level game sequencer for the LED racer. It steps the game through MENU, COUNTDOWN, RACE and FINISHED. It gates player movement and latches the winner(s) when any player reaches the last LED. It also drives `is_in_menu` and the position-clear pulse used by the screen manager and the player position counters.

Parameters:
- MAX_POS, 109, number of LED positions per lap; finish position = MAX_POS-1
- COUNT_STEPS, 3, countdown steps shown before the race starts (≥1)
- COUNT_TICKS, 50000000, clock cycles per countdown step (≥2)
- WIN_HOLD_TICKS, 250000000, clock cycles FINISHED is held before auto-return to MENU (≥2)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_pulse  in  1  one-cycle, already synchronised/debounced start button event
- abort_pulse  in  1  one-cycle abort event (long-press handled upstream)
- green_cur_pos  in  $clog2(MAX_POS)  green player position
- red_cur_pos  in  $clog2(MAX_POS)  red player position
- blue_cur_pos  in  $clog2(MAX_POS)  blue player position
- yellow_cur_pos  in  $clog2(MAX_POS)  yellow player position
- is_in_menu  out  1  high in MENU
- race_active  out  1  high in RACE; enables player movement
- countdown  out  $clog2(COUNT_STEPS+1)  remaining countdown step, 0 outside COUNTDOWN
- clear_pos  out  1  one-cycle pulse telling position counters to return to 0
- winner  out  4  one-hot-or-multi flags {yellow, blue, red, green}, bit0 = green
- tie  out  1  more than one winner bit set
- state  out  2  encoding: MENU=0, COUNTDOWN=1, RACE=2, FINISHED=3

Behaviour:
- Clocking and reset: all state and outputs are registered on the rising edge of clk. When rst_n is low, the block goes asynchronously to MENU, at any time including mid-countdown or mid-race. Reset values:
  - is_in_menu=1
  - race_active=0, countdown=0, clear_pos=0, winner=0, tie=0, state=0
  - internal tick and hold counters = 0
- abort_pulse: in any state other than MENU, moves to MENU next cycle. Counters, winner and tie are cleared. It has priority over every other event in the same cycle. In MENU it is ignored.
- MENU:
  - start_pulse → COUNTDOWN.
  - On that edge: countdown=COUNT_STEPS, tick counter=0, winner=0, tie=0.
  - clear_pos is high for exactly the first COUNTDOWN cycle.
- COUNTDOWN:
  - Tick counter increments every cycle, wrapping from COUNT_TICKS-1 to 0.
  - On wrap with countdown>1: countdown decrements.
  - On wrap with countdown==1: enter RACE, countdown=0.
  - Total COUNTDOWN duration = COUNT_STEPS×COUNT_TICKS cycles.
  - start_pulse is ignored.
- RACE:
  - race_active=1.
  - Each cycle, each position is compared for equality with MAX_POS-1. Values ≥ MAX_POS never count as a finish.
  - If any match: the next edge enters FINISHED and race_active drops on that same edge. winner latches all players matching in that cycle; tie = popcount(winner)>1.
  - Simultaneous arrivals in the same cycle produce multiple winner bits. There is no priority between players.
  - start_pulse is ignored.
- FINISHED:
  - winner and tie hold their values. Hold counter counts from 0.
  - When the hold counter reaches WIN_HOLD_TICKS-1, MENU is entered next edge.
  - start_pulse in FINISHED returns to MENU next edge (early exit).
  - Positions are ignored.
  - On entry to MENU, winner and tie are cleared.
- is_in_menu, race_active and countdown are decoded from the registered state and update on the same edge as state.
- Only one state transition happens per cycle. There are no illegal states: encoding 3 is FINISHED and all 2-bit codes are used.

Test Plan:
Use overrides COUNT_STEPS=3, COUNT_TICKS=4, WIN_HOLD_TICKS=8, MAX_POS=109 (finish=108).
1. Reset then start: assert rst_n low, release, start_pulse at cycle 5. Expect state=1, clear_pos=1 for one cycle, and countdown sequence 3,3,3,3,2,2,2,2,1,1,1,1. Then state=2 and race_active=1 exactly 12 cycles after entering COUNTDOWN.
2. Single winner: in RACE, drive red_cur_pos=108 for one cycle. Expect state=3, winner=4'b0010, tie=0 and race_active=0 next edge. After 8 cycles expect state=0, is_in_menu=1, winner=0.
3. Tie: in RACE, drive green=108 and yellow=108 in the same cycle. Expect winner=4'b1001 and tie=1. Then drive blue=108 while in FINISHED: winner stays 4'b1001.
4. Out-of-range and pre-race positions: drive green=108 during COUNTDOWN and blue=110 during RACE. Expect no transition to FINISHED.
5. Abort and early exit: abort_pulse together with start_pulse mid-COUNTDOWN gives MENU next cycle with countdown=0. start_pulse in FINISHED at hold count 2 gives MENU next edge.
6. Async reset mid-race: pull rst_n low between clock edges during RACE. Expect immediate state=0, race_active=0, is_in_menu=1 with no clock edge required.
